// File: rtl/lib_switch_rr_allocator.sv
// Per-output round-robin switch allocator for an NxM packet crossbar.
// Selects/grants are combinational; lock, owner and rotation pointer are registered per output.
module lib_switch_rr_allocator #(
    parameter int unsigned N = 5,
    parameter int unsigned M = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic [N-1:0][M-1:0] i_req,
    input  logic [N-1:0]        i_tail,
    input  logic [M-1:0]        i_out_ready,
    output logic [M-1:0][N-1:0] o_sel,
    output logic [N-1:0]        o_grant
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    typedef logic [IdxW-1:0] idx_t;

    logic [M-1:0]        lock_q, lock_d;
    idx_t [M-1:0]        owner_q, owner_d;
    idx_t [M-1:0]        ptr_q, ptr_d;

    logic [N-1:0][M-1:0] hreq;
    logic [M-1:0][N-1:0] elig;
    logic [M-1:0]        xfer;
    idx_t [M-1:0]        xfer_idx;
    logic [IdxW:0]       pick;

    // Returns {found, index} of the first eligible input at or after ptr, wrapping at N-1.
    function automatic logic [IdxW:0] rr_pick(input logic [N-1:0] el, input idx_t ptr);
        logic [IdxW:0] res;
        idx_t          cand;
        res = '0;
        for (int k = 0; k < int'(N); k++) begin
            cand = idx_t'((int'(ptr) + k) % int'(N));
            if (el[cand] && !res[IdxW]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Keep only the lowest set request bit of each input, then view requests per output.
    always_comb begin
        elig = '0;
        for (int n = 0; n < int'(N); n++) begin
            hreq[n] = i_req[n] & (~i_req[n] + M'(1));
            for (int m = 0; m < int'(M); m++) begin
                elig[m][n] = hreq[n][m];
            end
        end
    end

    always_comb begin
        o_sel    = '0;
        o_grant  = '0;
        xfer     = '0;
        xfer_idx = '0;
        pick     = '0;
        for (int m = 0; m < int'(M); m++) begin
            pick = rr_pick(elig[m], ptr_q[m]);
            if (lock_q[m]) begin
                // Path is held for the owner even when it stalls or drops its request.
                o_sel[m][owner_q[m]] = 1'b1;
                xfer[m]              = ce & i_out_ready[m] & hreq[owner_q[m]][m];
                xfer_idx[m]          = owner_q[m];
            end else begin
                xfer[m]     = ce & i_out_ready[m] & pick[IdxW];
                xfer_idx[m] = pick[IdxW-1:0];
                if (xfer[m]) begin
                    o_sel[m][xfer_idx[m]] = 1'b1;
                end
            end
            if (xfer[m]) begin
                o_grant[xfer_idx[m]] = 1'b1;
            end
        end
        if (!reset_n) begin
            o_sel   = '0;
            o_grant = '0;
        end
    end

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        for (int m = 0; m < int'(M); m++) begin
            if (xfer[m]) begin
                if (lock_q[m]) begin
                    if (i_tail[owner_q[m]]) begin
                        lock_d[m] = 1'b0;
                    end
                end else begin
                    ptr_d[m] = (xfer_idx[m] == idx_t'(N - 1)) ? '0 : xfer_idx[m] + 1'b1;
                    if (!i_tail[xfer_idx[m]]) begin
                        lock_d[m]  = 1'b1;
                        owner_d[m] = xfer_idx[m];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (ce) begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_lib_switch_rr_allocator.sv
// Scoreboard bench for lib_switch_rr_allocator: directed scenarios then random traffic,
// expectations from a packet-level reference model, checked by an independent monitor.
module tb_lib_switch_rr_allocator;

    localparam int N = 5;
    localparam int M = 5;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                ce = 1'b0;
    logic [N-1:0][M-1:0] req = '0;
    logic [N-1:0]        tail = '0;
    logic [M-1:0]        rdy = '0;
    logic [M-1:0][N-1:0] sel;
    logic [N-1:0]        gnt;

    lib_switch_rr_allocator #(
        .N(N),
        .M(M)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .i_req      (req),
        .i_tail     (tail),
        .i_out_ready(rdy),
        .o_sel      (sel),
        .o_grant    (gnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [M-1:0][N-1:0] sel;
        logic [N-1:0]        gnt;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_tests = 0;
    int    n_fail = 0;
    string phase = "init";

    // Reference state: which input holds each output, and where the next rotation starts.
    int    m_lock[M];
    int    m_owner[M];
    int    m_ptr[M];

    function automatic logic [M-1:0] oh(input int m);
        logic [M-1:0] v;
        v    = '0;
        v[m] = 1'b1;
        return v;
    endfunction

    task automatic model_push(input logic [N-1:0][M-1:0] r, input logic [N-1:0] t,
                              input logic [M-1:0] rd, input logic c, input logic rs);
        exp_t e;
        int   tgt[N];
        int   w;
        e = '0;
        if (!rs) begin
            for (int m = 0; m < M; m++) begin
                m_lock[m]  = 0;
                m_owner[m] = 0;
                m_ptr[m]   = 0;
            end
            exp_q.push_back(e);
            return;
        end
        for (int n = 0; n < N; n++) begin
            tgt[n] = -1;
            for (int m = M - 1; m >= 0; m--) begin
                if (r[n][m]) tgt[n] = m;
            end
        end
        for (int m = 0; m < M; m++) begin
            if (m_lock[m] != 0) begin
                e.sel[m][m_owner[m]] = 1'b1;
                if (c && rd[m] && tgt[m_owner[m]] == m) begin
                    e.gnt[m_owner[m]] = 1'b1;
                    if (t[m_owner[m]]) m_lock[m] = 0;
                end
            end else if (c && rd[m]) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (tgt[(m_ptr[m] + k) % N] == m) begin
                        w = (m_ptr[m] + k) % N;
                        break;
                    end
                end
                if (w >= 0) begin
                    e.sel[m][w] = 1'b1;
                    e.gnt[w]    = 1'b1;
                    m_ptr[m]    = (w + 1) % N;
                    if (!t[w]) begin
                        m_lock[m]  = 1;
                        m_owner[m] = w;
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [N-1:0][M-1:0] r, input logic [N-1:0] t,
                       input logic [M-1:0] rd, input logic c, input logic rs);
        req     = r;
        tail    = t;
        rdy     = rd;
        ce      = c;
        reset_n = rs;
        model_push(r, t, rd, c, rs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_tests++;
                if (sel !== mon_e.sel) begin
                    n_fail++;
                    $display("FAIL %s o_sel: got %h expected %h (t=%0t)", phase, sel, mon_e.sel,
                             $time);
                end
                n_tests++;
                if (gnt !== mon_e.gnt) begin
                    n_fail++;
                    $display("FAIL %s o_grant: got %b expected %b (t=%0t)", phase, gnt,
                             mon_e.gnt, $time);
                end
            end
        end
    end

    initial begin
        logic [N-1:0][M-1:0] r;
        logic [N-1:0]        t;
        logic [M-1:0]        rd;
        int                  x;

        @(posedge clk);
        #1;

        phase = "reset";
        r = '1;
        cyc(r, '1, '1, 1'b1, 1'b0);
        cyc(r, '1, '1, 1'b1, 1'b0);

        phase = "rr_rotate";
        for (int n = 0; n < N; n++) r[n] = oh(2);
        for (int i = 0; i < 6; i++) cyc(r, '1, '1, 1'b1, 1'b1);

        phase = "lock";
        cyc('0, '0, '1, 1'b1, 1'b0);
        r = '0;
        r[3] = oh(0);
        cyc(r, '0, '1, 1'b1, 1'b1);
        r[1] = oh(0);
        cyc(r, '0, '1, 1'b1, 1'b1);
        cyc(r, '0, '1, 1'b1, 1'b1);
        t = '0;
        t[3] = 1'b1;
        cyc(r, t, '1, 1'b1, 1'b1);
        r[3] = '0;
        cyc(r, '1, '1, 1'b1, 1'b1);

        phase = "backpressure";
        cyc('0, '0, '1, 1'b1, 1'b0);
        r = '0;
        r[2] = oh(4);
        t = '0;
        cyc(r, t, '1, 1'b1, 1'b1);
        r[0] = oh(4);
        cyc(r, t, '1, 1'b1, 1'b1);
        rd = '1;
        rd[4] = 1'b0;
        for (int i = 0; i < 3; i++) cyc(r, t, rd, 1'b1, 1'b1);
        cyc(r, t, '1, 1'b1, 1'b1);
        t[2] = 1'b1;
        cyc(r, t, '1, 1'b1, 1'b1);
        cyc(r, '1, '1, 1'b1, 1'b1);

        phase = "parallel";
        cyc('0, '0, '1, 1'b1, 1'b0);
        r = '0;
        r[0] = oh(1);
        r[1] = oh(0);
        r[2] = oh(3);
        r[3] = oh(2);
        cyc(r, '1, '1, 1'b1, 1'b1);

        phase = "ce_multi_req";
        r[4] = oh(1) | oh(3);
        for (int i = 0; i < 3; i++) cyc(r, '0, '1, 1'b0, 1'b1);
        cyc(r, '0, '1, 1'b1, 1'b1);
        cyc(r, '0, '1, 1'b0, 1'b1);

        phase = "mid_reset";
        cyc('0, '0, '1, 1'b1, 1'b0);
        r = '0;
        r[1] = oh(0);
        cyc(r, '0, '1, 1'b1, 1'b1);
        cyc(r, '0, '1, 1'b1, 1'b1);
        cyc(r, '0, '1, 1'b1, 1'b0);
        r[0] = oh(0);
        cyc(r, '1, '1, 1'b1, 1'b1);
        cyc(r, '1, '1, 1'b1, 1'b1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < N; n++) begin
                x = $urandom_range(0, 9);
                if (x < 3) r[n] = '0;
                else if (x < 8) r[n] = oh($urandom_range(0, M - 1));
                else r[n] = M'($urandom_range(1, (1 << M) - 1));
                t[n] = ($urandom_range(0, 2) == 0);
            end
            for (int m = 0; m < M; m++) rd[m] = ($urandom_range(0, 4) != 0);
            cyc(r, t, rd, ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) != 0));
        end

        phase = "drain";
        cyc('0, '0, '1, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
